sdr_read_path: RTL and testbench

SDR_READ_PATH -- requirements
Module: sdr_read_path

---
 rtl/sdr_read_path_pkg.sv | 18 +
 rtl/sdr_read_path_if.sv | 28 ++
 rtl/sdr_dly_line.sv | 32 +++
 rtl/sdr_read_path.sv | 102 ++++++++++
 tb/tb_sdr_read_path.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/sdr_read_path_pkg.sv
// Shared SDRAM parameters and read-path flag payload.
// The write data path uses the same defaults.
package sdr_read_path_pkg;

  localparam int unsigned SDR_DSIZE   = 16;
  localparam int unsigned SDR_CAS_LAT = 3;
  localparam int unsigned SDR_LSIZE   = 9;

  // Per-word control flags that travel down the CAS-latency pipe next to the data slot
  typedef struct packed {
    logic exp;   // a word is expected on DQ in the matching cycle
    logic lst;   // final word of a normally completed burst
    logic abt;   // final word of a terminated burst
  } rd_flags_t;

  localparam int unsigned RD_FLAGS_W = $bits(rd_flags_t);

endpackage

// File: rtl/sdr_read_path_if.sv
// Read-path bus between the SDRAM command sequencer and the read data capture.
interface sdr_read_path_if #(
  parameter int unsigned DSIZE = sdr_read_path_pkg::SDR_DSIZE,
  parameter int unsigned LSIZE = sdr_read_path_pkg::SDR_LSIZE
) ();

  logic             RD_CMD;
  logic [LSIZE-1:0] RD_LEN;
  logic             TERM;
  logic [DSIZE-1:0] DQIN;
  logic [DSIZE-1:0] RDATA;
  logic             RDATA_VALID;
  logic             RDATA_LAST;
  logic             RD_ABORT;
  logic             BUSY;
  logic             ERR;

  modport master (
    output RD_CMD, RD_LEN, TERM, DQIN,
    input  RDATA, RDATA_VALID, RDATA_LAST, RD_ABORT, BUSY, ERR
  );

  modport slave (
    input  RD_CMD, RD_LEN, TERM, DQIN,
    output RDATA, RDATA_VALID, RDATA_LAST, RD_ABORT, BUSY, ERR
  );

endinterface

// File: rtl/sdr_dly_line.sv
// Fixed-depth shift register with synchronous clear.
// Also reports the OR of every stage so callers can tell whether anything is in flight.
module sdr_dly_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             CLK,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] any_c
);

  logic [WIDTH-1:0] stage_q [0:DEPTH-1];

  always_ff @(posedge CLK) begin
    if (clr) begin
      for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[DEPTH-1];

  always_comb begin
    any_c = '0;
    for (int i = 0; i < int'(DEPTH); i++) any_c = any_c | stage_q[i];
  end

endmodule

// File: rtl/sdr_read_path.sv
// SDRAM read data path: tracks issued burst words and captures DQ after CAS latency,
// tagging each captured word as normal-last or aborted-last.
module sdr_read_path
  import sdr_read_path_pkg::*;
#(
  parameter int unsigned DSIZE   = SDR_DSIZE,
  parameter int unsigned CAS_LAT = SDR_CAS_LAT,
  parameter int unsigned LSIZE   = SDR_LSIZE
) (
  input logic             CLK,
  input logic             RESET_N,
  sdr_read_path_if.slave  bus
);

  // One stage resolves a word's abort flag, the delay line covers the rest of CAS latency
  localparam int unsigned DLY_DEPTH = CAS_LAT - 1;

  logic [LSIZE-1:0] rem_q, rem_d;
  logic             iss_exp_q, iss_exp_d;
  logic             iss_lst_q, iss_lst_d;
  logic             accept_c;
  logic             abort_c;
  logic             busy_d;
  rd_flags_t        res_c;
  rd_flags_t        dly_c;
  rd_flags_t        pend_c;

  logic [DSIZE-1:0] rdata_q;
  logic             rdata_valid_q;
  logic             rdata_last_q;
  logic             rd_abort_q;
  logic             busy_q;
  logic             err_q;

  // Issue tracking: accept, terminate or count down the current burst
  always_comb begin
    rem_d     = rem_q;
    iss_exp_d = 1'b0;
    iss_lst_d = 1'b0;
    accept_c  = bus.RD_CMD && (rem_q <= LSIZE'(1)) && (bus.RD_LEN != '0);
    if (accept_c) begin
      rem_d     = bus.RD_LEN - LSIZE'(1);
      iss_exp_d = 1'b1;
      iss_lst_d = (bus.RD_LEN == LSIZE'(1));
    end else if (bus.TERM) begin
      rem_d = '0;
    end else if (rem_q != '0) begin
      rem_d     = rem_q - LSIZE'(1);
      iss_exp_d = 1'b1;
      iss_lst_d = (rem_q == LSIZE'(1));
    end
    // Last cycle's word is cut short when a terminate or a new READ lands before its burst finished
    abort_c   = (accept_c || bus.TERM) && iss_exp_q && !iss_lst_q;
    res_c.exp = iss_exp_q;
    res_c.lst = iss_lst_q;
    res_c.abt = abort_c;
    busy_d    = (rem_d != '0) || iss_exp_d || iss_exp_q || (|pend_c);
  end

  sdr_dly_line #(
    .WIDTH (RD_FLAGS_W),
    .DEPTH (DLY_DEPTH)
  ) u_dly (
    .CLK   (CLK),
    .clr   (!RESET_N),
    .din   (res_c),
    .dout  (dly_c),
    .any_c (pend_c)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      rem_q         <= '0;
      iss_exp_q     <= 1'b0;
      iss_lst_q     <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      rdata_last_q  <= 1'b0;
      rd_abort_q    <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      rem_q         <= rem_d;
      iss_exp_q     <= iss_exp_d;
      iss_lst_q     <= iss_lst_d;
      rdata_valid_q <= dly_c.exp;
      rdata_last_q  <= dly_c.exp && dly_c.lst;
      rd_abort_q    <= dly_c.exp && dly_c.abt;
      busy_q        <= busy_d;
      err_q         <= bus.RD_CMD && !accept_c;
      if (dly_c.exp) rdata_q <= bus.DQIN;
    end
  end

  assign bus.RDATA       = rdata_q;
  assign bus.RDATA_VALID = rdata_valid_q;
  assign bus.RDATA_LAST  = rdata_last_q;
  assign bus.RD_ABORT    = rd_abort_q;
  assign bus.BUSY        = busy_q;
  assign bus.ERR         = err_q;

endmodule

// File: tb/tb_sdr_read_path.sv
// Directed and scoreboarded bench for sdr_read_path at CAS latency 3 and 2.
module tb_sdr_read_path;
  import sdr_read_path_pkg::*;

  localparam int unsigned DW = SDR_DSIZE;
  localparam int unsigned LW = SDR_LSIZE;

  logic CLK = 1'b0;
  logic RESET_N;
  always #5 CLK = ~CLK;

  sdr_read_path_if #(.DSIZE(DW), .LSIZE(LW)) bus3 ();
  sdr_read_path_if #(.DSIZE(DW), .LSIZE(LW)) bus2 ();

  sdr_read_path #(.DSIZE(DW), .CAS_LAT(3), .LSIZE(LW)) u_dut3 (
    .CLK(CLK), .RESET_N(RESET_N), .bus(bus3));
  sdr_read_path #(.DSIZE(DW), .CAS_LAT(2), .LSIZE(LW)) u_dut2 (
    .CLK(CLK), .RESET_N(RESET_N), .bus(bus2));

  typedef struct {
    logic [15:0] d;
    logic        l;
    logic        a;
  } exp_t;

  int   cyc;
  int   n_run;
  int   n_fail;
  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_dq();
    bus3.DQIN = DW'(32'hA000 + 32'(cyc));
    bus2.DQIN = DW'(32'hA000 + 32'(cyc));
  endtask

  task automatic step();
    @(posedge CLK);
    cyc++;
    #1;
    set_dq();
  endtask

  task automatic drive(input logic cmd, input int len, input logic term);
    bus3.RD_CMD = cmd; bus3.RD_LEN = LW'(len); bus3.TERM = term;
    bus2.RD_CMD = cmd; bus2.RD_LEN = LW'(len); bus2.TERM = term;
  endtask

  task automatic start_test();
    RESET_N = 1'b0;
    drive(1'b0, 0, 1'b0);
    repeat (3) step();
    RESET_N = 1'b1;
    cyc = 5;
    set_dq();
  endtask

  // Compare every output of one DUT against the expected cycle values
  task automatic chk(input string t, input int sel, input logic v, input logic l, input logic a,
                     input logic b, input logic e, input logic cd);
    logic [15:0] gd;
    logic        gv, gl, ga, gb, ge;
    logic [15:0] d;
    if (sel == 3) begin
      gd = bus3.RDATA; gv = bus3.RDATA_VALID; gl = bus3.RDATA_LAST;
      ga = bus3.RD_ABORT; gb = bus3.BUSY; ge = bus3.ERR;
    end else begin
      gd = bus2.RDATA; gv = bus2.RDATA_VALID; gl = bus2.RDATA_LAST;
      ga = bus2.RD_ABORT; gb = bus2.BUSY; ge = bus2.ERR;
    end
    d = v ? 16'(32'hA000 + 32'(cyc) - 32'd1) : 16'h0000;
    check($sformatf("%s.c%0d.valid", t, cyc), 32'(gv), 32'(v));
    check($sformatf("%s.c%0d.last",  t, cyc), 32'(gl), 32'(l));
    check($sformatf("%s.c%0d.abort", t, cyc), 32'(ga), 32'(a));
    check($sformatf("%s.c%0d.busy",  t, cyc), 32'(gb), 32'(b));
    check($sformatf("%s.c%0d.err",   t, cyc), 32'(ge), 32'(e));
    if (v || cd) check($sformatf("%s.c%0d.rdata", t, cyc), 32'(gd), 32'(d));
  endtask

  initial begin
    int   m_rem;
    logic prev_iss;
    logic cmd, term;
    int   len;
    exp_t ent;

    cyc = 0; n_run = 0; n_fail = 0;
    RESET_N = 1'b0;
    drive(1'b0, 0, 1'b0);
    set_dq();

    // CL3 single burst of 4, reset state checked at c5
    start_test();
    while (cyc <= 20) begin
      drive(cyc == 10, 4, 1'b0);
      chk("A", 3, cyc >= 14 && cyc <= 17, cyc == 17, 1'b0, cyc >= 11 && cyc <= 17, 1'b0, cyc == 5);
      step();
    end

    // CL2 back-to-back bursts of 2 with no gap
    start_test();
    while (cyc <= 19) begin
      drive(cyc == 10 || cyc == 12, 2, 1'b0);
      chk("B", 2, cyc >= 13 && cyc <= 16, cyc == 14 || cyc == 16, 1'b0,
          cyc >= 11 && cyc <= 16, 1'b0, 1'b0);
      step();
    end

    // CL3 burst of 8 terminated at c13
    start_test();
    while (cyc <= 20) begin
      drive(cyc == 10, 8, cyc == 13);
      chk("C", 3, cyc >= 14 && cyc <= 16, 1'b0, cyc == 16, cyc >= 11 && cyc <= 16, 1'b0, 1'b0);
      step();
    end

    // CL3 rejected overlapping command and zero-length command
    start_test();
    while (cyc <= 30) begin
      drive(cyc == 10 || cyc == 12 || cyc == 25, (cyc == 12) ? 3 : (cyc == 25) ? 0 : 8, 1'b0);
      chk("D", 3, cyc >= 14 && cyc <= 21, cyc == 21, 1'b0, cyc >= 11 && cyc <= 21,
          cyc == 13 || cyc == 26, 1'b0);
      step();
    end

    // CL3 reset in the middle of a burst
    start_test();
    while (cyc <= 22) begin
      RESET_N = (cyc == 15) ? 1'b0 : 1'b1;
      drive(cyc == 10, 4, 1'b0);
      chk("E", 3, cyc >= 14 && cyc <= 15, 1'b0, 1'b0, cyc >= 11 && cyc <= 15, 1'b0, cyc >= 16);
      step();
    end

    // CL3 random seamless bursts with occasional terminate, against an issue-order scoreboard
    start_test();
    m_rem = 0;
    prev_iss = 1'b0;
    sb_q.delete();
    for (int n = 0; n < 340; n++) begin
      if (bus3.RDATA_VALID) begin
        if (sb_q.size() == 0) begin
          check($sformatf("R.c%0d.extra_word", cyc), 32'd1, 32'd0);
        end else begin
          ent = sb_q.pop_front();
          check($sformatf("R.c%0d.rdata", cyc), 32'(bus3.RDATA), 32'(ent.d));
          check($sformatf("R.c%0d.last",  cyc), 32'(bus3.RDATA_LAST), 32'(ent.l));
          check($sformatf("R.c%0d.abort", cyc), 32'(bus3.RD_ABORT), 32'(ent.a));
        end
      end else if (bus3.RDATA_LAST || bus3.RD_ABORT) begin
        check($sformatf("R.c%0d.flag_no_valid", cyc), 32'd1, 32'd0);
      end
      if (bus3.ERR) check($sformatf("R.c%0d.err", cyc), 32'(bus3.ERR), 32'd0);

      cmd  = 1'b0;
      term = 1'b0;
      len  = 0;
      if (n < 300) begin
        cmd  = (m_rem == 0) && ($urandom_range(0, 2) != 0);
        len  = $urandom_range(1, 6);
        term = !cmd && ($urandom_range(0, 9) == 0);
      end
      if (cmd) begin
        sb_q.push_back('{d: 16'(32'hA000 + 32'(cyc) + 32'd3), l: (len == 1), a: 1'b0});
        m_rem = len - 1;
        prev_iss = 1'b1;
      end else if (term) begin
        if (prev_iss && sb_q.size() != 0 && !sb_q[sb_q.size()-1].l) begin
          ent = sb_q[sb_q.size()-1];
          ent.a = 1'b1;
          sb_q[sb_q.size()-1] = ent;
        end
        m_rem = 0;
        prev_iss = 1'b0;
      end else if (m_rem != 0) begin
        sb_q.push_back('{d: 16'(32'hA000 + 32'(cyc) + 32'd3), l: (m_rem == 1), a: 1'b0});
        m_rem--;
        prev_iss = 1'b1;
      end else begin
        prev_iss = 1'b0;
      end
      drive(cmd, len, term);
      step();
    end
    check("R.drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
